// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the fetch / load-store memory arbiter.
//   arb_state_t        : arbiter FSM state (IDLE, REQ, WAIT)
//   GNT_IF / GNT_LS    : grant / owner encoding
//   FETCH_RESET_VECTOR : first fetch address after core reset
//   pick_winner()      : round-robin winner selection between the two requesters
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LS = 1'b1;

    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h1C00_0000;

    // A lone requester always wins. Under contention the side that did not
    // win last time gets the grant, so neither side can starve the other.
    function automatic logic pick_winner(input logic if_valid,
                                         input logic ls_valid,
                                         input logic last_grant);
        if (if_valid && ls_valid) begin
            return ~last_grant;
        end else if (ls_valid) begin
            return GNT_LS;
        end else begin
            return GNT_IF;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request/response port between the fetch
// stage (reads only) and the load/store unit (reads and writes). One
// transaction is outstanding at a time; contention is resolved round-robin.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_req_valid/if_req_ready       fetch request handshake, if_addr
//   if_rsp_valid/if_rdata           fetch response (rdata is mem_rdata)
//   ls_req_valid/ls_req_ready       load/store request handshake
//   ls_addr/ls_we/ls_wstrb/ls_wdata load/store request fields
//   ls_rsp_valid/ls_rdata           load data / write acknowledge
//   mem_req_valid/mem_req_ready     downstream request handshake
//   mem_addr/we/wstrb/wdata         latched request fields
//   mem_rsp_valid/mem_rdata         downstream response
//
// Handshakes: a request transfers in a cycle where valid and ready are both
// high. A requester that is not granted sees ready low and must hold valid and
// its fields until granted. Responses are single-cycle pulses with no ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          state;
    arb_state_t          state_next;
    logic                owner;
    logic                last_grant;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_we;
    logic [STRB_W-1:0]   lat_wstrb;
    logic [DATA_W-1:0]   lat_wdata;

    logic                any_req;
    logic                winner;
    logic                accept;

    assign any_req = if_req_valid | ls_req_valid;
    assign winner  = pick_winner(if_req_valid, ls_req_valid, last_grant);
    assign accept  = (state == IDLE) && any_req;

    // State register plus the request latch, which loads only on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= GNT_IF;
            last_grant <= GNT_LS;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wstrb  <= '0;
            lat_wdata  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner      <= winner;
                last_grant <= winner;
                if (winner == GNT_LS) begin
                    lat_addr  <= ls_addr;
                    lat_we    <= ls_we;
                    lat_wstrb <= ls_wstrb;
                    lat_wdata <= ls_wdata;
                end else begin
                    // Fetches are plain reads: clear the write-side fields.
                    lat_addr  <= if_addr;
                    lat_we    <= 1'b0;
                    lat_wstrb <= '0;
                    lat_wdata <= '0;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req)       state_next = REQ;
            REQ:     if (mem_req_ready) state_next = WAIT;
            WAIT:    if (mem_rsp_valid) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Output logic. Responses arriving outside WAIT never reach a requester.
    always_comb begin
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        if_rsp_valid  = 1'b0;
        ls_rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if_req_ready = any_req && (winner == GNT_IF);
                ls_req_ready = any_req && (winner == GNT_LS);
            end
            REQ: begin
                mem_req_valid = 1'b1;
            end
            WAIT: begin
                if_rsp_valid = mem_rsp_valid && (owner == GNT_IF);
                ls_rsp_valid = mem_rsp_valid && (owner == GNT_LS);
            end
            default: begin
            end
        endcase
    end

    assign mem_addr  = lat_addr;
    assign mem_we    = lat_we;
    assign mem_wstrb = lat_wstrb;
    assign mem_wdata = lat_wdata;

    // Read data is a straight pass-through; rsp_valid alone qualifies it.
    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the fetch stage (instruction reads) and the load/store unit (data reads/writes). Accepts one request at a time from either side, drives it onto the downstream memory request/response handshake, and routes the response back to the owner. Sits between the pipeline and the memory/bus interface; one outstanding transaction, round-robin when both sides contend.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; write strobe width is DATA_W/8

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- if_req_valid  in  1  fetch requests a read
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_addr  in  ADDR_W  data address
- ls_we  in  1  1 = write
- ls_wstrb  in  DATA_W/8  byte enables (writes)
- ls_wdata  in  DATA_W  write data
- ls_rsp_valid  out  1  read data valid / write acknowledged
- ls_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_we, mem_wstrb, mem_wdata  out  ADDR_W/1/DATA_W/8/DATA_W  latched request fields
- mem_rsp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM: IDLE, REQ, WAIT. Registers: state, owner (IF/LS), last_grant, latched addr/we/wstrb/wdata.
- IDLE: if any req_valid, pick winner: only one valid -> it; both valid -> the one not equal to last_grant. Assert winner's req_ready (combinational, only in IDLE), latch its fields (fetch: we=0, wstrb=0, wdata=0), set owner and last_grant, -> REQ. Loser's req_ready stays 0; it must hold valid and fields.
- REQ: mem_req_valid=1, mem_* = latched fields (stable until accepted). mem_req_ready=1 -> WAIT.
- WAIT: on mem_rsp_valid, owner's rsp_valid=1 and rdata=mem_rdata (combinational pass-through, single cycle), -> IDLE. Other side's rsp_valid=0.
- if_rdata/ls_rdata driven from mem_rdata always; only rsp_valid qualifies.
- mem_rsp_valid outside WAIT is ignored.
- Writes complete with a response (ls_rsp_valid), rdata don't-care.

## Timing
- Reset: state=IDLE, last_grant=LS (so first contended grant goes to IF), owner=IF, latched fields 0; all *_ready, *_valid outputs 0, mem_* data outputs 0.
- Request accepted cycle N -> mem_req_valid from N+1; with mem_req_ready=1 at N+1, WAIT at N+2; response earliest N+2.
- Next request accepted earliest the cycle after rsp_valid (IDLE re-entered); min 3 cycles per transaction.
- Backpressure: mem_req_ready low holds REQ indefinitely, fields unchanged.
- Reset in REQ/WAIT: transaction dropped, no rsp_valid pulsed; memory side is reset concurrently.
- Simultaneous new requests while busy: ready stays 0, no latching.

## Structure
- Shared package: state enum (IDLE/REQ/WAIT), grant encoding constants (GNT_IF=0, GNT_LS=1), fetch reset vector 32'h1C000000 for benches.
- Single module, no sub-module; winner selection is a small function in the package.

## Test plan
- Fetch read 0x1C000000, memory ready immediately, rdata 0x02800000 one cycle later -> if_req_ready at N, mem_req_valid N+1 addr 0x1C000000 we=0, if_rsp_valid with 0x02800000, ls_rsp_valid never.
- Both valid after reset (if 0x1C000004, ls read 0x00001000) -> IF granted first, then LS, then IF again if both still valid.
- LS write addr 0x2000, wstrb 4'b0011, wdata 0xDEADBEEF -> mem_we=1, fields exact on bus, ls_rsp_valid on response.
- mem_req_ready low 5 cycles -> mem_req_valid and fields stable all 5, no ready to either requester, single handshake afterwards.
- Stray mem_rsp_valid in IDLE -> no rsp_valid output.
- Reset asserted in WAIT -> next cycle all outputs 0, IDLE; later response ignored; fresh fetch completes normally.
